parking_code_tx: RTL and testbench

- Transmitter end of the parking-gate serial sensor line: turns gate entry/exit requests into fixed-length serial code frames on single-bit line x, one bit per clock.
- x drives the code-detector FSM's x input.
- Also tracks lot occupancy, and refuses entries when full and exits when empty, so the line never carries an impossible event.

---
 rtl/parking_pkg.sv | 15 +
 rtl/parking_code_shifter.sv | 49 ++++
 rtl/parking_code_tx.sv | 113 +++++++++++
 tb/tb_parking_code_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared constants and state type for the parking-gate serial code line (transmitter and detector).
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    localparam int unsigned CODE_W_DEF   = 4;
    localparam logic [3:0]  ENTRY_CODE_DEF = 4'b1011;
    localparam logic [3:0]  EXIT_CODE_DEF  = 4'b1101;
    localparam int unsigned CAPACITY_DEF = 7;

endpackage

// File: rtl/parking_code_shifter.sv
// Serialises one code word MSB first onto x; optional even-parity bit under PARKING_TX_PARITY_EN.
module parking_code_shifter #(
    parameter int unsigned CODE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CODE_W-1:0] code,
    output logic              x,
    output logic              last_c
);

`ifdef PARKING_TX_PARITY_EN
    localparam int unsigned FRAME_W = CODE_W + 1;
`else
    localparam int unsigned FRAME_W = CODE_W;
`endif
    localparam int unsigned CNT_BITS = $clog2(FRAME_W);

    logic [FRAME_W-1:0]  sreg;
    logic [FRAME_W-1:0]  frame_c;
    logic [CNT_BITS-1:0] cnt;

`ifdef PARKING_TX_PARITY_EN
    assign frame_c = {code, ^code};
`else
    assign frame_c = code;
`endif

    // Zero fill means the line falls back to 0 on its own once the word is out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= frame_c;
            cnt  <= '0;
        end else begin
            sreg <= {sreg[FRAME_W-2:0], 1'b0};
            if (cnt != CNT_BITS'(FRAME_W - 1)) begin
                cnt <= cnt + CNT_BITS'(1);
            end
        end
    end

    assign x      = sreg[FRAME_W-1];
    assign last_c = (cnt == CNT_BITS'(FRAME_W - 1));

endmodule

// File: rtl/parking_code_tx.sv
// Parking-gate transmitter: arbitrates entry/exit, tracks occupancy, sends code frames on x.
// Optional parity bit per frame when PARKING_TX_PARITY_EN is defined.
module parking_code_tx
    import parking_pkg::*;
#(
    parameter int unsigned       CODE_W     = CODE_W_DEF,
    parameter logic [CODE_W-1:0] ENTRY_CODE = ENTRY_CODE_DEF,
    parameter logic [CODE_W-1:0] EXIT_CODE  = EXIT_CODE_DEF,
    parameter int unsigned       GAP_CYC    = 2,
    parameter int unsigned       CAPACITY   = CAPACITY_DEF,
    parameter int unsigned       CNT_W      = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             entry_req,
    input  logic             exit_req,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             frame_done,
    output logic             reject,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);

    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    tx_state_e         state;
    logic [GAP_W-1:0]  gap_cnt;
    logic              accept_exit_c;
    logic              accept_entry_c;
    logic              load_c;
    logic              last_c;
    logic [CODE_W-1:0] code_c;

    // Exit wins arbitration; an exit request masks entry for that cycle even when refused.
    assign accept_exit_c  = (state == IDLE) && exit_req && !empty;
    assign accept_entry_c = (state == IDLE) && !exit_req && entry_req && !full;
    assign load_c         = accept_exit_c || accept_entry_c;
    assign code_c         = accept_exit_c ? EXIT_CODE : ENTRY_CODE;

    parking_code_shifter #(
        .CODE_W (CODE_W)
    ) u_shifter (
        .clk    (CLK),
        .rst    (RESET),
        .load   (load_c),
        .code   (code_c),
        .x      (x),
        .last_c (last_c)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            occupancy  <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            reject     <= 1'b0;
            ready      <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            reject     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_exit_c) begin
                        occupancy <= occupancy - CNT_W'(1);
                        empty     <= (occupancy == CNT_W'(1));
                        full      <= 1'b0;
                        state     <= SEND;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end else if (accept_entry_c) begin
                        occupancy <= occupancy + CNT_W'(1);
                        full      <= (occupancy == CNT_W'(CAPACITY - 1));
                        empty     <= 1'b0;
                        state     <= SEND;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end else if (exit_req || entry_req) begin
                        reject <= 1'b1;
                    end
                end
                SEND: begin
                    if (last_c) begin
                        state      <= GAP;
                        gap_cnt    <= '0;
                        frame_done <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_code_tx.sv
// Scoreboard bench for parking_code_tx: stimulus queues expected frames/rejects, monitor checks the line.
module tb_parking_code_tx;

`ifdef PARKING_TX_PARITY_EN
    localparam int FW = 5;
    localparam logic [7:0] ENTRY_FRAME = 8'b0001_0111;
    localparam logic [7:0] EXIT_FRAME  = 8'b0001_1011;
`else
    localparam int FW = 4;
    localparam logic [7:0] ENTRY_FRAME = 8'b0000_1011;
    localparam logic [7:0] EXIT_FRAME  = 8'b0000_1101;
`endif
    localparam int GAP = 2;

    logic       CLK;
    logic       RESET;
    logic       entry_req;
    logic       exit_req;
    logic       ready;
    logic       x;
    logic       busy;
    logic       frame_done;
    logic       reject;
    logic [2:0] occupancy;
    logic       full;
    logic       empty;

    typedef struct packed {
        logic       is_frame;
        logic [7:0] bits;
        logic [2:0] occ;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    parking_code_tx dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .ready      (ready),
        .x          (x),
        .busy       (busy),
        .frame_done (frame_done),
        .reject     (reject),
        .occupancy  (occupancy),
        .full       (full),
        .empty      (empty)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: follows each frame from busy rising to the return of ready, and each reject pulse.
    initial begin : monitor
        bit         collecting;
        int         pos;
        logic [7:0] got;
        exp_t       e;
        collecting = 1'b0;
        pos        = 0;
        got        = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                if (collecting && sb.size() > 0) void'(sb.pop_front());
                collecting = 1'b0;
            end else begin
                if (!collecting && busy) begin
                    collecting = 1'b1;
                    pos        = 0;
                    got        = '0;
                end
                if (collecting) begin
                    if (pos < FW) begin
                        got = {got[6:0], x};
                        chk("fd_in_send", 32'(frame_done), 0);
                        chk("ready_in_send", 32'(ready), 0);
                    end else if (pos == FW) begin
                        chk("fd_first_gap", 32'(frame_done), 1);
                        chk("x_gap", 32'(x), 0);
                    end else if (pos < FW + GAP) begin
                        chk("x_gap", 32'(x), 0);
                        chk("fd_late", 32'(frame_done), 0);
                        chk("busy_gap", 32'(busy), 1);
                    end else begin
                        chk("ready_after", 32'(ready), 1);
                        chk("busy_after", 32'(busy), 0);
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_frame act=%0h exp=none", got);
                        end else begin
                            e = sb.pop_front();
                            chk("kind_frame", 32'(e.is_frame), 1);
                            chk("frame_bits", 32'(got), 32'(e.bits));
                            chk("frame_occ", 32'(occupancy), 32'(e.occ));
                        end
                        collecting = 1'b0;
                    end
                    pos++;
                end else begin
                    chk("x_idle", 32'(x), 0);
                    if (reject) begin
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_reject act=1 exp=0");
                        end else begin
                            e = sb.pop_front();
                            chk("kind_reject", 32'(e.is_frame), 0);
                            chk("reject_occ", 32'(occupancy), 32'(e.occ));
                        end
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL wait_ready_timeout act=0 exp=1");
        end
    endtask

    task automatic issue(input logic is_exit, input logic [2:0] occ);
        wait_ready();
        if (is_exit) exit_req = 1'b1;
        else entry_req = 1'b1;
        sb.push_back('{1'b1, is_exit ? EXIT_FRAME : ENTRY_FRAME, occ});
        @(posedge CLK);
        #1;
        exit_req  = 1'b0;
        entry_req = 1'b0;
    endtask

    task automatic do_frame(input logic is_exit, input logic [2:0] occ);
        issue(is_exit, occ);
        wait_ready();
    endtask

    task automatic do_reject(input logic is_exit, input int holds, input logic [2:0] occ);
        wait_ready();
        if (is_exit) exit_req = 1'b1;
        else entry_req = 1'b1;
        for (int i = 0; i < holds; i++) begin
            sb.push_back('{1'b0, 8'h00, occ});
            @(posedge CLK);
            #1;
        end
        exit_req  = 1'b0;
        entry_req = 1'b0;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        #1;
        chk("rst_x", 32'(x), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_empty", 32'(empty), 1);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin : stim
        RESET     = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("init_ready", 32'(ready), 1);
        chk("init_x", 32'(x), 0);
        chk("init_occ", 32'(occupancy), 0);
        chk("init_empty", 32'(empty), 1);
        chk("init_full", 32'(full), 0);
        chk("init_busy", 32'(busy), 0);
        chk("init_fd", 32'(frame_done), 0);
        chk("init_reject", 32'(reject), 0);

        do_frame(1'b0, 3'd1);
        do_frame(1'b0, 3'd2);
        do_frame(1'b0, 3'd3);

        // Both requests at occupancy 3: exit first, held entry follows.
        wait_ready();
        exit_req  = 1'b1;
        entry_req = 1'b1;
        sb.push_back('{1'b1, EXIT_FRAME, 3'd2});
        sb.push_back('{1'b1, ENTRY_FRAME, 3'd3});
        @(posedge CLK);
        #1;
        exit_req = 1'b0;
        wait_ready();
        @(posedge CLK);
        #1;
        entry_req = 1'b0;
        wait_ready();
        chk("both_occ", 32'(occupancy), 3);

        for (int i = 4; i <= 7; i++) do_frame(1'b0, 3'(i));
        chk("full_at_cap", 32'(full), 1);
        do_reject(1'b0, 1, 3'd7);
        repeat (3) @(posedge CLK);
        #1;
        chk("occ_after_full_reject", 32'(occupancy), 7);
        chk("full_held", 32'(full), 1);

        apply_reset();
        do_reject(1'b1, 3, 3'd0);
        repeat (3) @(posedge CLK);
        #1;
        chk("occ_after_empty_reject", 32'(occupancy), 0);
        chk("empty_held", 32'(empty), 1);

        // Abort a frame during its third bit.
        issue(1'b0, 3'd1);
        repeat (2) @(posedge CLK);
        #1;
        chk("third_bit", 32'(x), 1);
        apply_reset();
        do_frame(1'b0, 3'd1);
        do_frame(1'b1, 3'd0);
        chk("empty_after_exit", 32'(empty), 1);
        chk("full_after_exit", 32'(full), 0);

        repeat (10) @(posedge CLK);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
